// File: rtl/wallace_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Wallace multiplier.
package wallace_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int PROD_W        = 2 * DEFAULT_WIDTH;

  function automatic int prod_w(int width);
    return 2 * width;
  endfunction

  // Number of partial-product bits landing in column c of a width x width array.
  function automatic int col_height(int width, int c);
    if (c < width) return c + 1;
    if (c < 2 * width - 1) return 2 * width - 1 - c;
    return 0;
  endfunction

  // Rows left after 'level' layers of 3:2 row compression.
  function automatic int rows_at(int width, int level);
    int r;
    r = width;
    for (int l = 0; l < level; l++) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int tree_levels(int width);
    int r;
    int l;
    r = width;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell composed from two half adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace reduction of a WIDTH x WIDTH partial-product matrix
// down to a redundant (sum, carry) pair of 2*WIDTH-bit vectors.
module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pp,
  output logic [2*WIDTH-1:0]          sum,
  output logic [2*WIDTH-1:0]          carry
);
  localparam int PW     = prod_w(WIDTH);
  localparam int LEVELS = tree_levels(WIDTH);

  logic [PW-1:0] rows [LEVELS+1][WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_init
    assign rows[0][i] = PW'(pp[i]) << i;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int R  = rows_at(WIDTH, l);
    localparam int G  = R / 3;
    localparam int RN = rows_at(WIDTH, l + 1);

    for (genvar g = 0; g < G; g++) begin : g_grp
      logic [PW-1:0] s;
      logic [PW-2:0] c;
      for (genvar b = 0; b < PW - 1; b++) begin : g_fa
        full_adder u_fa (
          .a   (rows[l][3*g][b]),
          .b   (rows[l][3*g+1][b]),
          .cin (rows[l][3*g+2][b]),
          .sum (s[b]),
          .cout(c[b])
        );
      end
      // Carry out of the top column falls outside the product width.
      assign s[PW-1] = rows[l][3*g][PW-1] ^ rows[l][3*g+1][PW-1] ^ rows[l][3*g+2][PW-1];
      assign rows[l+1][2*g]   = s;
      assign rows[l+1][2*g+1] = {c, 1'b0};
    end

    for (genvar k = 0; k < R % 3; k++) begin : g_pass
      assign rows[l+1][2*G+k] = rows[l][3*G+k];
    end

    for (genvar k = RN; k < WIDTH; k++) begin : g_zero
      assign rows[l+1][k] = '0;
    end
  end

  assign sum   = rows[LEVELS][0];
  assign carry = rows[LEVELS][1];

endmodule

// File: rtl/wallace_pipe_multiplier.sv
// Three-stage pipelined unsigned Wallace multiplier with optional low-column
// truncation and a single global stall driven by output backpressure.
module wallace_pipe_multiplier
  import wallace_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_approx
);
  localparam int PW = prod_w(WIDTH);

  logic                           adv;
  logic                           s1_valid;
  logic [WIDTH-1:0]               s1_a;
  logic [WIDTH-1:0]               s1_b;
  mode_e                          s1_mode;
  logic [WIDTH-1:0][WIDTH-1:0]    pp;
  logic [PW-1:0]                  tree_sum;
  logic [PW-1:0]                  tree_carry;
  logic                           s2_valid;
  logic [PW-1:0]                  s2_sum;
  logic [PW-1:0]                  s2_carry;
  mode_e                          s2_mode;

  // Whole pipeline freezes only when a finished result is being refused.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !rst;

  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (s1_mode == MODE_APPROX && (i + j) < APPROX_COLS) pp[i][j] = 1'b0;
        else pp[i][j] = s1_a[i] & s1_b[j];
      end
    end
  end

  wallace_csa_tree #(.WIDTH(WIDTH)) u_tree (
    .pp   (pp),
    .sum  (tree_sum),
    .carry(tree_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_mode    <= MODE_EXACT;
      s2_valid   <= 1'b0;
      s2_sum     <= '0;
      s2_carry   <= '0;
      s2_mode    <= MODE_EXACT;
      out_valid  <= 1'b0;
      out        <= '0;
      out_approx <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in1;
        s1_b    <= in2;
        s1_mode <= mode_e'(approx_en);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= tree_sum;
        s2_carry <= tree_carry;
        s2_mode  <= s1_mode;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out        <= s2_sum + s2_carry;
        out_approx <= (s2_mode == MODE_APPROX);
      end
    end
  end

endmodule

// File: tb/tb_wallace_pipe_multiplier.sv
// Directed and randomised checks of the pipelined Wallace multiplier (WIDTH=8, APPROX_COLS=4).
module tb_wallace_pipe_multiplier;
  localparam int W  = 8;
  localparam int AC = 4;
  localparam int N_RAND = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        approx_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        out_approx;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] p;
    logic        ap;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  wallace_pipe_multiplier #(.WIDTH(W), .APPROX_COLS(AC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_approx(out_approx)
  );

  function automatic logic [15:0] ref_mult(logic [7:0] a, logic [7:0] b, logic ap);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && !(ap && (i + j) < AC)) r = r + (16'd1 << (i + j));
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ap);
    in1 = a; in2 = b; approx_en = ap; in_valid = 1'b1;
  endtask

  // Cycle index (relative to the accepting cycle) at which out_valid is first seen; -1 on timeout.
  task automatic wait_out(input int start, output int n);
    n = start;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) return;
      n++;
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; approx_en = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out !== 16'd0) begin fails++; $display("FAIL reset_out: got %0d expected 0", out); end
    tests++; if (out_approx !== 1'b0) begin fails++; $display("FAIL reset_out_approx: got %b expected 0", out_approx); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_exact_stream();
    int n;
    next_cycle();
    drive(8'd255, 8'd255, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    wait_out(1, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL exact_latency: got %0d expected 3", n); end
    tests++; if (out !== 16'hFE01) begin fails++; $display("FAIL exact_out: got %h expected fe01", out); end
    tests++; if (out_approx !== 1'b0) begin fails++; $display("FAIL exact_mode: got %b expected 0", out_approx); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL exact_single: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_approx_stream();
    int n;
    next_cycle();
    drive(8'd255, 8'd255, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    wait_out(1, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL approx_latency: got %0d expected 3", n); end
    tests++; if (out !== 16'hFDD0) begin fails++; $display("FAIL approx_out: got %h expected fdd0", out); end
    tests++; if (out[3:0] !== 4'd0) begin fails++; $display("FAIL approx_low_bits: got %h expected 0", out[3:0]); end
    tests++; if (out_approx !== 1'b1) begin fails++; $display("FAIL approx_mode: got %b expected 1", out_approx); end
  endtask

  task automatic test_back_to_back();
    int n;
    next_cycle();
    drive(8'd3, 8'd5, 1'b1);
    next_cycle();
    drive(8'd3, 8'd5, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    wait_out(2, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL b2b_latency: got %0d expected 3", n); end
    tests++; if (out !== 16'd0 || out_approx !== 1'b1) begin fails++; $display("FAIL b2b_first: got %0d/%b expected 0/1", out, out_approx); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out !== 16'd15 || out_approx !== 1'b0) begin
      fails++; $display("FAIL b2b_second: got v=%b %0d/%b expected v=1 15/0", out_valid, out, out_approx);
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_tail: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] seq [3];
    seq[0] = 16'd200; seq[1] = 16'd63; seq[2] = 16'd300;
    next_cycle();
    drive(8'd10, 8'd20, 1'b0);
    next_cycle();
    drive(8'd7, 8'd9, 1'b0);
    next_cycle();
    drive(8'd100, 8'd3, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    wait_out(3, n);
    out_ready = 1'b0;
    tests++; if (n !== 3 || out !== seq[0]) begin fails++; $display("FAIL bp_first: got lat %0d out %0d expected lat 3 out 200", n, out); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out !== seq[0] || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_stall_%0d: got v=%b out=%0d in_ready=%b expected v=1 out=200 in_ready=0", k, out_valid, out, in_ready);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out !== seq[k]) begin
        fails++; $display("FAIL bp_drain_%0d: got v=%b out=%0d expected v=1 out=%0d", k, out_valid, out, seq[k]);
      end
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_tail: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    int n;
    next_cycle();
    drive(8'd11, 8'd13, 1'b0);
    next_cycle();
    drive(8'd9, 8'd9, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    tests++; if (out !== 16'd0) begin fails++; $display("FAIL rst_out: got %0d expected 0", out); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_stale_%0d: got out_valid %b out %0d expected 0", k, out_valid, out); end
    end
    next_cycle();
    drive(8'd6, 8'd7, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    wait_out(1, n);
    tests++; if (n !== 3) begin fails++; $display("FAIL rst_new_latency: got %0d expected 3", n); end
    tests++; if (out !== 16'd42) begin fails++; $display("FAIL rst_new_out: got %0d expected 42", out); end
  endtask

  task automatic test_random_sweep();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit took_in = 1'b0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_out = '0;
    exp_t e;
    q.delete();
    in_valid = 1'b0;
    while (got < N_RAND && cyc < 60000) begin
      next_cycle();
      cyc++;
      if (!in_valid || took_in) begin
        if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
          in_valid  = 1'b1;
          in1       = 8'($urandom_range(0, 255));
          in2       = 8'($urandom_range(0, 255));
          approx_en = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        tests++;
        if (out_valid !== 1'b1 || out !== prev_out) begin
          fails++; $display("FAIL rand_hold: got v=%b out=%0d expected v=1 out=%0d", out_valid, out, prev_out);
        end
      end
      took_in = in_valid && in_ready;
      if (took_in) begin
        e.p  = ref_mult(in1, in2, approx_en);
        e.ap = approx_en;
        q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_extra: got unexpected result %0d expected none", out);
        end else begin
          e = q.pop_front();
          got++;
          if (out !== e.p || out_approx !== e.ap) begin
            fails++; $display("FAIL rand_result_%0d: got %0d/%b expected %0d/%b", got, out, out_approx, e.p, e.ap);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
    tests++; if (got != N_RAND) begin fails++; $display("FAIL rand_count: got %0d results expected %0d", got, N_RAND); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_exact_stream();
    test_approx_stream();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wallace_pipe_multiplier.md
Name: wallace_pipe_multiplier

Overview:
Parametrised, pipelined unsigned Wallace-tree multiplier. It is the successor to the fixed 3-bit combinational Wallace multiplier. It adds:
- configurable operand width;
- a runtime-selectable approximate mode that zeroes the low partial-product columns;
- a valid/ready handshake on input and output, with backpressure.

It sits between operand producers and the accumulator/error-analysis datapath of the approximate-multiplier study.

Parameters:
WIDTH, 8, operand width in bits (legal range 3..16).
APPROX_COLS, 4, number of low partial-product columns (weights 2^0 .. 2^(APPROX_COLS-1)) dropped when approx_en=1. Legal range 0..2*WIDTH-1; 0 makes approx mode exact.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
in1  input  WIDTH  multiplicand, unsigned
in2  input  WIDTH  multiplier, unsigned
approx_en  input  1  per-transaction mode: 0 = exact, 1 = approximate; sampled with the operands
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  2*WIDTH  product
out_approx  output  1  mode the result was computed in

Behaviour:
Reset and clocking:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out=0, out_approx=0, all internal stage valid bits 0.
- in_ready is combinational. It is 0 while rst=1.

Pipeline:
- Three stages; each stage register has its own valid bit.
- S1: register in1, in2, approx_en.
- S2: generate the WIDTH*WIDTH partial products, with masking applied (see below). Reduce them through the Wallace 3:2/2:2 compressor tree to two 2*WIDTH vectors (sum, carry). Register both vectors plus the mode bit.
- S3: final carry-propagate add, sum+carry, truncated to 2*WIDTH bits. Register into out / out_approx.

Handshake and stall:
- Transfer on input occurs when in_valid && in_ready. Transfer on output occurs when out_valid && out_ready.
- Global advance enable: adv = !(out_valid && !out_ready). in_ready = adv && !rst.
- When adv=0, every stage holds its contents; out and out_valid stay stable until accepted.
- Bubbles do not collapse; the pipeline moves as one unit.
- Latency is exactly 3 cycles from input transfer to out_valid, with no stall in between. Throughput is 1 result per cycle when out_ready is held at 1.
- An accepted transaction is never dropped or duplicated. Order is preserved.

Arithmetic:
- Partial product pp[i][j] = in1[i] & in2[j], with column weight c = i + j.
- If approx_en=1 and c < APPROX_COLS, pp[i][j] is forced to 0.
- Exact mode: out = in1*in2.
- Approx mode: out = sum of pp[i][j]*2^(i+j) over c >= APPROX_COLS. Hence out[APPROX_COLS-1:0] = 0 in approx mode.
- The result never overflows 2*WIDTH bits.

Boundary conditions:
- Zero operands give 0 in both modes.
- With all-ones operands in approx mode, the deficit equals the maximal truncation error.
- approx_en may change every transaction; the mode travels with its data.
- Reset asserted mid-operation: all in-flight transactions are discarded. The first out_valid after reset deassertion is no earlier than 3 cycles after the first accepted input.
- in_valid while in_ready=0: the operands are not captured. The source must hold them.

Decomposition:
Shared package (wallace_pkg):
- localparam function for the column height of column c;
- constant for PROD_W = 2*WIDTH;
- the mode enum {MODE_EXACT=0, MODE_APPROX=1}.

Sub-module: wallace_csa_tree. Combinational, parametrised by WIDTH. Input: the masked partial-product matrix. Output: sum and carry vectors. It is built from the existing half_adder and full_adder cells. The top level owns the masking, the pipeline registers, the handshake and the final adder.

Test Plan:
All scenarios use WIDTH=8 and APPROX_COLS=4.
1. Exact, streaming: in1=255, in2=255, approx_en=0, out_ready=1 -> out_valid 3 cycles later, out=0xFE01 (65025), out_approx=0.
2. Approx, streaming: in1=255, in2=255, approx_en=1 -> out=0xFDD0 (64976; dropped columns sum to 49), low 4 bits zero, out_approx=1.
3. Fully dropped: in1=3, in2=5, approx_en=1 -> out=0; same operands with approx_en=0 -> out=15. Sent back to back, results arrive in order on consecutive cycles.
4. Backpressure: stream 3 transactions (10*20, 7*9, 100*3), hold out_ready=0 for 5 cycles after the first out_valid.
   - Required: out stays at 200 and in_ready=0 during the stall.
   - After release: 200, 63, 300 on consecutive cycles, none lost or duplicated.
5. Reset mid-flight: accept 2 transactions, assert rst for 1 cycle.
   - Required: out_valid=0, out=0 the next cycle, and no stale results ever emerge.
   - A new transaction 6*7 yields 42 with 3-cycle latency.
6. Random sweep: 10k random operand pairs with random approx_en and random out_ready.
   - Required: every result matches the reference model (exact product, or masked-column sum) in order.
